// File: rtl/mem_bus_router_if.sv
// Single-beat valid/ready memory bus shared by the CPU, BRAM and IO sides of mem_bus_router.
// The master drives the request; the slave answers with ready and rdata.
interface mem_bus_router_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_router.sv
// Routes one CPU request at a time to the BRAM or IO window, or answers it with bus_error.
// Optional ACCESS watchdog: define MEM_BUS_TIMEOUT_EN.
module mem_bus_router #(
  parameter logic [31:0] BRAM_BASE      = 32'h0000_0000,
  parameter logic [31:0] BRAM_SIZE      = 32'h0000_8000,
  parameter logic [31:0] IO_BASE        = 32'h1000_0000,
  parameter logic [31:0] IO_SIZE        = 32'h0000_0100,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_bus_router_if.slave   mem,
  mem_bus_router_if.master  bram,
  mem_bus_router_if.master  io,
  output logic              bus_error
);

  if (TIMEOUT_CYCLES == 0 || (BRAM_SIZE & (BRAM_SIZE - 32'd1)) != 32'd0 ||
      (IO_SIZE & (IO_SIZE - 32'd1)) != 32'd0) begin : g_param_check
    $error("mem_bus_router: window sizes must be powers of two, TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;
  typedef enum logic [1:0] {TgtNone, TgtBram, TgtIo} tgt_e;

  state_e      state_q;
  tgt_e        tgt_q;
  tgt_e        tgt_dec;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        bram_valid_q;
  logic        io_valid_q;
  logic        ready_q;
  logic        error_q;
  logic        sel_ready;
  logic [31:0] sel_rdata;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
`endif

  always_comb begin
    tgt_dec = TgtNone;
    if ((mem.addr & ~(BRAM_SIZE - 32'd1)) == BRAM_BASE) begin
      tgt_dec = TgtBram;
    end else if ((mem.addr & ~(IO_SIZE - 32'd1)) == IO_BASE) begin
      tgt_dec = TgtIo;
    end
  end

  // Only the latched target's ready counts; a stray ready from the other slave is ignored.
  assign sel_ready = (tgt_q == TgtBram) ? bram.ready : ((tgt_q == TgtIo) && io.ready);
  assign sel_rdata = (tgt_q == TgtBram) ? bram.rdata : io.rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tgt_q        <= TgtNone;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      rdata_q      <= 32'h0;
      bram_valid_q <= 1'b0;
      io_valid_q   <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem.valid) begin
            addr_q  <= mem.addr;
            wdata_q <= mem.wdata;
            wstrb_q <= mem.wstrb;
            tgt_q   <= tgt_dec;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (tgt_dec == TgtNone) begin
              rdata_q <= 32'h0;
              ready_q <= 1'b1;
              error_q <= 1'b1;
              state_q <= StRespond;
            end else begin
              bram_valid_q <= (tgt_dec == TgtBram);
              io_valid_q   <= (tgt_dec == TgtIo);
              state_q      <= StAccess;
            end
          end
        end
        StAccess: begin
          if (sel_ready) begin
            rdata_q      <= sel_rdata;
            bram_valid_q <= 1'b0;
            io_valid_q   <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= StRespond;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            rdata_q      <= 32'hDEAD_BEEF;
            bram_valid_q <= 1'b0;
            io_valid_q   <= 1'b0;
            ready_q      <= 1'b1;
            error_q      <= 1'b1;
            state_q      <= StRespond;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StRespond: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign mem.ready  = ready_q;
  assign mem.rdata  = rdata_q;
  assign bus_error  = error_q;

  assign bram.valid = bram_valid_q;
  assign bram.addr  = addr_q;
  assign bram.wdata = wdata_q;
  assign bram.wstrb = wstrb_q;

  assign io.valid   = io_valid_q;
  assign io.addr    = addr_q;
  assign io.wdata   = wdata_q;
  assign io.wstrb   = wstrb_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Randomised bench for mem_bus_router: behavioural BRAM/IO slaves plus a transaction-level model.
// Build with MEM_BUS_TIMEOUT_EN to exercise the ACCESS watchdog instead of the indefinite wait.
module tb_mem_bus_router;
  localparam logic [31:0] BramBase = 32'h0000_0000;
  localparam logic [31:0] BramSize = 32'h0000_8000;
  localparam logic [31:0] IoBase   = 32'h1000_0000;
  localparam logic [31:0] IoSize   = 32'h0000_0100;
  localparam int unsigned Timeout  = 64;

  logic clk;
  logic reset_n;
  logic bus_error;

  mem_bus_router_if mem_if ();
  mem_bus_router_if bram_if ();
  mem_bus_router_if io_if ();

  mem_bus_router #(
    .BRAM_BASE      (BramBase),
    .BRAM_SIZE      (BramSize),
    .IO_BASE        (IoBase),
    .IO_SIZE        (IoSize),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem       (mem_if),
    .bram      (bram_if),
    .io        (io_if),
    .bus_error (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave models: ready after the valid has been seen for <lat> cycles, optionally held one more.
  logic [31:0] bram_store [logic [29:0]];
  logic [31:0] ref_mem    [logic [29:0]];
  int   b_lat = 4, b_cnt = 0, io_lat = 2, io_cnt = 0;
  bit   b_never = 0, io_never = 0, b_hold2 = 0, b_extra = 0;

  always @(negedge clk) begin
    if (b_extra) begin
      bram_if.ready = 1'b1;
      b_extra = 0;
    end else if (bram_if.valid && !b_never) begin
      b_cnt++;
      if (b_cnt == b_lat) begin
        bram_if.ready = 1'b1;
        b_cnt = 0;
        b_extra = b_hold2;
        if (bram_if.wstrb == 4'hF) bram_store[bram_if.addr[31:2]] = bram_if.wdata;
        bram_if.rdata = bram_store.exists(bram_if.addr[31:2]) ? bram_store[bram_if.addr[31:2]]
                                                              : 32'h0;
      end else begin
        bram_if.ready = 1'b0;
      end
    end else begin
      bram_if.ready = 1'b0;
      b_cnt = 0;
    end
    if (io_if.valid && !io_never) begin
      io_cnt++;
      io_if.ready = (io_cnt == io_lat);
      if (io_cnt == io_lat) io_cnt = 0;
      io_if.rdata = 32'hA5A5_0000 | {24'h0, io_if.addr[9:2]};
    end else begin
      io_if.ready = 1'b0;
      io_cnt = 0;
    end
  end

  // One CPU transaction; expectations come from the address map and the slave latencies.
  task automatic do_txn(input logic [31:0] addr, input bit write, input logic [31:0] wdata);
    int kind, exp_n, n, bad_sel, bad_stable;
    bit got, err;
    logic [31:0] rdata, exp_rdata;
    logic [3:0]  strb;
    strb = write ? 4'hF : 4'h0;
    if ((addr & ~(BramSize - 1)) == BramBase) kind = 1;
    else if ((addr & ~(IoSize - 1)) == IoBase) kind = 2;
    else kind = 0;
    exp_n = (kind == 1) ? b_lat + 1 : (kind == 2) ? io_lat + 1 : 1;
    exp_rdata = 32'h0;
    if (kind == 1) exp_rdata = ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0;
    if (kind == 2) exp_rdata = 32'hA5A5_0000 + ((addr - IoBase) >> 2);
    if (kind == 1 && write) ref_mem[addr[31:2]] = wdata;
    @(negedge clk);
    mem_if.valid = 1'b1;
    mem_if.addr  = addr;
    mem_if.wdata = wdata;
    mem_if.wstrb = strb;
    @(posedge clk);
    #1;
    // Inputs are don't-care once accepted; scramble them and maybe drop valid.
    mem_if.valid = 1'($urandom_range(0, 1));
    mem_if.addr  = $urandom;
    mem_if.wdata = $urandom;
    mem_if.wstrb = $urandom_range(0, 1) ? 4'hF : 4'h0;
    n = 0; got = 0; err = 0; rdata = 32'h0; bad_sel = 0; bad_stable = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (kind != 1 && bram_if.valid) bad_sel++;
      if (kind != 2 && io_if.valid) bad_sel++;
      if (bram_if.valid && (bram_if.addr !== addr || bram_if.wdata !== wdata ||
                            bram_if.wstrb !== strb)) bad_stable++;
      if (io_if.valid && (io_if.addr !== addr || io_if.wdata !== wdata ||
                          io_if.wstrb !== strb)) bad_stable++;
      if (mem_if.ready) begin
        got = 1;
        err = bus_error;
        rdata = mem_if.rdata;
        mem_if.valid = 1'b0;
        check("valid_drop_at_ready", {31'h0, bram_if.valid | io_if.valid}, 32'h0);
      end else if (bus_error) begin
        bad_sel++;
      end
    end
    check("ready_seen", {31'h0, got}, 32'h1);
    check("latency", n, exp_n);
    check("bus_error", {31'h0, err}, (kind == 0) ? 32'h1 : 32'h0);
    check("other_valid_low", bad_sel, 0);
    check("req_stable", bad_stable, 0);
    if (!write) check("rdata", rdata, exp_rdata);
    @(negedge clk);
    check("ready_one_cycle", {31'h0, mem_if.ready | bus_error}, 32'h0);
    @(negedge clk);
    check("no_retrigger", {31'h0, mem_if.ready}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int got_ready;
    reset_n = 1'b0;
    mem_if.valid = 1'b0; mem_if.addr = 32'h0; mem_if.wdata = 32'h0; mem_if.wstrb = 4'h0;
    bram_if.ready = 1'b0; bram_if.rdata = 32'h0;
    io_if.ready = 1'b0; io_if.rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", {31'h0, mem_if.ready}, 32'h0);
    check("rst_valids", {30'h0, bram_if.valid, io_if.valid}, 32'h0);
    check("rst_bus_error", {31'h0, bus_error}, 32'h0);
    check("rst_rdata", mem_if.rdata, 32'h0);
    check("rst_latched_addr", bram_if.addr, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    do_txn(32'h0000_0040, 1, 32'h1234_5678);
    do_txn(32'h0000_0040, 0, 32'h0);
    do_txn(32'h1000_0004, 0, 32'h0);
    do_txn(32'h2000_0000, 0, 32'h0);
    do_txn(32'h2000_0000, 1, 32'hFFFF_FFFF);
    b_hold2 = 1;
    do_txn(32'h0000_0040, 0, 32'h0);
    b_hold2 = 0;

    // Reset in the middle of a BRAM access.
    b_never = 1;
    @(negedge clk);
    mem_if.valid = 1'b1; mem_if.addr = 32'h0000_0080; mem_if.wstrb = 4'h0;
    @(negedge clk);
    mem_if.valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_bram_valid", {31'h0, bram_if.valid}, 32'h1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_bram_valid", {31'h0, bram_if.valid}, 32'h0);
    check("rst_no_ready", {31'h0, mem_if.ready | bus_error}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    b_never = 0;
    do_txn(32'h0000_0040, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      b_lat = $urandom_range(1, 4);
      io_lat = $urandom_range(1, 4);
      b_hold2 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0, 1: a = BramBase + ($urandom_range(0, 15) << 2);
        2:    a = IoBase + ($urandom_range(0, 63) << 2);
        3:    a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
        default: a = 32'h0000_8000 + ($urandom_range(0, 1023) << 2);
      endcase
      do_txn(a, 1'($urandom_range(0, 1)), $urandom);
    end
    b_hold2 = 0;

`ifdef MEM_BUS_TIMEOUT_EN
    io_never = 1;
    @(negedge clk);
    mem_if.valid = 1'b1; mem_if.addr = 32'h1000_0010; mem_if.wstrb = 4'h0;
    @(negedge clk);
    mem_if.valid = 1'b0;
    got_ready = 0;
    for (int n = 1; n <= 200 && got_ready == 0; n++) begin
      if (mem_if.ready) begin
        got_ready = n;
        check("timeout_rdata", mem_if.rdata, 32'hDEAD_BEEF);
        check("timeout_error", {31'h0, bus_error}, 32'h1);
      end else begin
        @(negedge clk);
      end
    end
    check("timeout_latency", got_ready, Timeout + 1);
    io_never = 0;
    repeat (2) @(negedge clk);
`else
    // Without the watchdog an unanswered access waits indefinitely.
    io_never = 1;
    io_lat = 2;
    @(negedge clk);
    mem_if.valid = 1'b1; mem_if.addr = 32'h1000_0010; mem_if.wstrb = 4'h0;
    @(negedge clk);
    mem_if.valid = 1'b0;
    got_ready = 0;
    for (int n = 0; n < 100; n++) begin
      if (mem_if.ready || bus_error) got_ready++;
      @(negedge clk);
    end
    check("hang_no_ready", got_ready, 0);
    check("hang_io_valid", {31'h0, io_if.valid}, 32'h1);
    io_never = 0;
    got_ready = 0;
    for (int n = 0; n < 20 && got_ready == 0; n++) begin
      @(negedge clk);
      if (mem_if.ready) begin
        got_ready = 1;
        check("late_rdata", mem_if.rdata, 32'hA5A5_0004);
        check("late_no_error", {31'h0, bus_error}, 32'h0);
      end
    end
    check("late_ready_seen", got_ready, 1);
    repeat (2) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
